// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and helpers for the memory stage
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & ~WORD_ALIGN_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unacknowledged request cycles, flags the last allowed one
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: word load/store over req/ack, single result to writeback
module mem_stage #(
  parameter int MAX_WAIT = 16,
  parameter int RD_W     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_mem_op,
  input  logic [31:0]     in_result_I,
  input  logic [31:0]     in_wdata,
  input  logic            in_result_P,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wb_en,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_pred,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wb_en,
  output logic            err_misalign,
  output logic            err_timeout
);

  import mem_stage_pkg::*;

  state_e  state;
  state_e  state_next;
  mem_op_e op;
  logic    accept;
  logic    is_mem;
  logic    aligned;
  logic    timer_expired;
  logic    held_wb_en;

  assign op       = mem_op_e'(in_mem_op);
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mem   = (op == MEM_LOAD) || (op == MEM_STORE);
  assign aligned  = is_aligned(in_result_I);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  ((state == BUSY) && !mem_ack),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (is_mem && aligned) ? BUSY : HOLD;
      BUSY: if (mem_ack || timer_expired) state_next = HOLD;
      HOLD: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == BUSY);
    out_valid = (state == HOLD);
  end

  // Result fields are loaded on the transition into HOLD and left untouched while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      out_data     <= 32'd0;
      out_pred     <= 1'b0;
      out_rd       <= '0;
      out_wb_en    <= 1'b0;
      held_wb_en   <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_misalign <= 1'b0;
      if (accept) begin
        out_pred   <= in_result_P;
        out_rd     <= in_rd;
        held_wb_en <= in_wb_en;
        if (is_mem && aligned) begin
          mem_addr  <= in_result_I & WORD_ALIGN_MASK;
          mem_we    <= (op == MEM_STORE);
          mem_wdata <= in_wdata;
        end else begin
          out_data     <= in_result_I;
          out_wb_en    <= in_wb_en && (op == MEM_NONE);
          err_misalign <= is_mem;
        end
      end else if (state == BUSY) begin
        if (mem_ack) begin
          out_data  <= mem_we ? mem_addr : mem_rdata;
          out_wb_en <= !mem_we && held_wb_en;
        end else if (timer_expired) begin
          out_data    <= 32'd0;
          out_wb_en   <= 1'b0;
          err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] data;
    logic        pred;
    logic [5:0]  rd;
    logic        wb_en;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mem_op;
  logic [31:0] in_result_I;
  logic [31:0] in_wdata;
  logic        in_result_P;
  logic [5:0]  in_rd;
  logic        in_wb_en;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_pred;
  logic [5:0]  out_rd;
  logic        out_wb_en;
  logic        err_misalign;
  logic        err_timeout;

  res_t exp_q[$];
  res_t got_q[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4), .RD_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_op    (in_mem_op),
    .in_result_I  (in_result_I),
    .in_wdata     (in_wdata),
    .in_result_P  (in_result_P),
    .in_rd        (in_rd),
    .in_wb_en     (in_wb_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_pred     (out_pred),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back(res_t'{out_data, out_pred, out_rd, out_wb_en});
  end

  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic pred, input logic [5:0] rd, input logic wb);
    @(posedge clk); #1;
    in_valid = 1'b1; in_mem_op = op; in_result_I = addr; in_wdata = wdata;
    in_result_P = pred; in_rd = rd; in_wb_en = wb;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_result(output bit ok, output res_t g, output res_t e);
    ok = 1'b0; g = '0; e = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (got_q.size() > 0) begin ok = 1'b1; break; end
    end
    if (ok && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
    end else begin
      ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else passed++;
    total++; if ({mem_req, out_valid, out_wb_en, err_misalign, err_timeout} !== 5'b0)
      $display("FAIL rst_flags got %b exp 00000", {mem_req, out_valid, out_wb_en, err_misalign, err_timeout}); else passed++;
    total++; if (out_data !== 32'd0) $display("FAIL rst_out_data got %h exp 0", out_data); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_alu();
    bit ok; res_t g, e;
    out_ready = 1'b1;
    exp_q.push_back(res_t'{32'h0000_1234, 1'b1, 6'd5, 1'b1});
    send(2'b00, 32'h0000_1234, 32'd0, 1'b1, 6'd5, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL alu_latency got %b exp 1", out_valid); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL alu_no_req got %b exp 0", mem_req); else passed++;
    get_result(ok, g, e);
    total++; if (!ok || g !== e) $display("FAIL alu_result got %h exp %h ok %0d", g, e, ok); else passed++;
  endtask

  task automatic test_load();
    bit ok; res_t g, e;
    out_ready = 1'b1;
    exp_q.push_back(res_t'{32'hDEAD_BEEF, 1'b0, 6'd7, 1'b1});
    send(2'b01, 32'h0000_0100, 32'd0, 1'b0, 6'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0)
        $display("FAIL ld_req%0d got req %b addr %h we %b exp 1 00000100 0", i, mem_req, mem_addr, mem_we); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL ld_in_ready%0d got %b exp 0", i, in_ready); else passed++;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL ld_done got req %b valid %b exp 0 1", mem_req, out_valid); else passed++;
    get_result(ok, g, e);
    total++; if (!ok || g !== e) $display("FAIL ld_result got %h exp %h ok %0d", g, e, ok); else passed++;
  endtask

  task automatic test_store();
    bit ok; res_t g, e;
    out_ready = 1'b1;
    exp_q.push_back(res_t'{32'h0000_0200, 1'b1, 6'd9, 1'b0});
    send(2'b10, 32'h0000_0200, 32'hCAFE_0001, 1'b1, 6'd9, 1'b1);
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_0001 || mem_addr !== 32'h200)
      $display("FAIL st_req got req %b we %b wdata %h addr %h exp 1 1 cafe0001 00000200", mem_req, mem_we, mem_wdata, mem_addr); else passed++;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL st_latency got valid %b req %b exp 1 0", out_valid, mem_req); else passed++;
    get_result(ok, g, e);
    total++; if (!ok || g !== e) $display("FAIL st_result got %h exp %h ok %0d", g, e, ok); else passed++;
  endtask

  task automatic test_misalign();
    bit ok; res_t g, e;
    out_ready = 1'b1;
    exp_q.push_back(res_t'{32'h0000_0103, 1'b0, 6'd3, 1'b0});
    send(2'b01, 32'h0000_0103, 32'd0, 1'b0, 6'd3, 1'b1);
    @(negedge clk);
    total++; if (err_misalign !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL mis_pulse got err %b req %b valid %b exp 1 0 1", err_misalign, mem_req, out_valid); else passed++;
    @(negedge clk);
    total++; if (err_misalign !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL mis_pulse_end got err %b req %b exp 0 0", err_misalign, mem_req); else passed++;
    get_result(ok, g, e);
    total++; if (!ok || g !== e) $display("FAIL mis_result got %h exp %h ok %0d", g, e, ok); else passed++;
  endtask

  task automatic test_timeout();
    bit ok; res_t g, e;
    out_ready = 1'b1;
    exp_q.push_back(res_t'{32'd0, 1'b1, 6'd4, 1'b0});
    send(2'b01, 32'h0000_0300, 32'd0, 1'b1, 6'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (mem_req !== 1'b1) $display("FAIL to_req%0d got %b exp 1", i, mem_req); else passed++;
    end
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || err_timeout !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL to_fire got req %b err %b valid %b exp 0 1 1", mem_req, err_timeout, out_valid); else passed++;
    get_result(ok, g, e);
    total++; if (!ok || g !== e) $display("FAIL to_result got %h exp %h ok %0d", g, e, ok); else passed++;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (err_timeout !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL to_late_ack%0d got err %b valid %b req %b exp 1 0 0", i, err_timeout, out_valid, mem_req); else passed++;
    end
    mem_ack = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (err_timeout !== 1'b0) $display("FAIL to_rst_clear got %b exp 0", err_timeout); else passed++;
  endtask

  task automatic test_hold_stall();
    bit ok; res_t g, e;
    out_ready = 1'b0;
    exp_q.push_back(res_t'{32'h0000_55AA, 1'b1, 6'd12, 1'b0});
    send(2'b11, 32'h0000_55AA, 32'd0, 1'b1, 6'd12, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_data !== 32'h55AA || out_rd !== 6'd12 || in_ready !== 1'b0)
        $display("FAIL hold%0d got valid %b data %h rd %0d ready %b exp 1 000055aa 12 0", i, out_valid, out_data, out_rd, in_ready); else passed++;
    end
    @(posedge clk); #1; out_ready = 1'b1;
    get_result(ok, g, e);
    total++; if (!ok || g !== e) $display("FAIL hold_result got %h exp %h ok %0d", g, e, ok); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_release got valid %b ready %b exp 0 1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_rst_busy();
    out_ready = 1'b1;
    send(2'b01, 32'h0000_0400, 32'd0, 1'b1, 6'd20, 1'b1);
    @(negedge clk);
    total++; if (mem_req !== 1'b1) $display("FAIL rb_req got %b exp 1", mem_req); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rb_reset got req %b valid %b ready %b exp 0 0 0", mem_req, out_valid, in_ready); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL rb_release got ready %b valid %b req %b exp 1 0 0", in_ready, out_valid, mem_req); else passed++;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL rb_late_ack got valid %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok; res_t g, e;
    logic [31:0] v;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      v = $urandom;
      exp_q.push_back(res_t'{v, v[0], 6'(n + 30), v[1]});
      send(2'b00, v, 32'd0, v[0], 6'(n + 30), v[1]);
      get_result(ok, g, e);
      total++; if (!ok || g !== e) $display("FAIL b2b%0d got %h exp %h ok %0d", n, g, e, ok); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mem_op = 2'b00; in_result_I = 32'd0; in_wdata = 32'd0;
    in_result_P = 1'b0; in_rd = 6'd0; in_wb_en = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_hold_stall();
    test_rst_busy();
    test_back_to_back();
    total++; if (exp_q.size() != 0 || got_q.size() != 0)
      $display("FAIL sb_drain got exp %0d got %0d left exp 0 0", exp_q.size(), got_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
